fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the async FIFO's write-clock domain among NREQ requesters. Sits in the wr_clk domain directly in front of the FIFO write handler. It grants one requester at a time for a burst of up to MAX_BURST beats and gates every beat with the FIFO's registered wr_full flag.

---
 rtl/fifo_wr_arbiter_pkg.sv | 30 +++
 rtl/fifo_wr_arbiter_if.sv | 28 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Covers the FSM state encoding, register width helpers and one-hot decoding.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int MAX_NREQ = 8;

  function automatic int ptr_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  // Index of the set bit. The input is assumed one-hot; all-zero decodes to 0.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle for the requester side and the FIFO write side of the arbiter.
// The master modport is the arbiter; the slave modport is requesters plus FIFO.
interface fifo_wr_arbiter_if #(
  parameter int NREQ     = 4,
  parameter int DATASIZE = 8
);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_last;
  logic [NREQ*DATASIZE-1:0] req_data;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0]          grant;
  logic                     wr_full;
  logic                     fifo_wr_en;
  logic [DATASIZE-1:0]      fifo_wr_data;
  logic                     busy;

  modport master (
    input  req_valid, req_last, req_data, wr_full,
    output req_ready, grant, fifo_wr_en, fifo_wr_data, busy
  );

  modport slave (
    output req_valid, req_last, req_data, wr_full,
    input  req_ready, grant, fifo_wr_en, fifo_wr_data, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching circularly from ptr.
// It returns the winner both as a one-hot vector and as an index.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  pick,
  output logic [PTR_W-1:0] pick_idx
);

  logic [PTR_W-1:0] cand;

  // Walk from the farthest candidate back to ptr so the nearest valid one wins.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        pick       = '0;
        pick[cand] = 1'b1;
      end
    end
    pick_idx = PTR_W'(onehot_to_idx(MAX_NREQ'(pick)));
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NREQ requesters in wr_clk.
// Grants bursts of up to MAX_BURST beats and gates every beat with wr_full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DATASIZE  = 8,
  parameter int MAX_BURST = 4
) (
  input logic          wr_clk,
  input logic          wr_rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int PTR_W = ptr_width(NREQ);
  localparam int CNT_W = cnt_width(MAX_BURST);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_BUSY = BUSY;

  logic [0:0]       state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] owner_idx_q, owner_idx_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [NREQ-1:0]     owner_valid;
  logic                beat;
  logic                abandon;
  logic                last_hit;
  logic                burst_end;
  logic [CNT_W-1:0]    cnt_inc;
  logic [PTR_W-1:0]    next_ptr;
  logic [PTR_W-1:0]    pick_ptr;
  logic [NREQ-1:0]     pick;
  logic [PTR_W-1:0]    pick_idx;
  logic [DATASIZE-1:0] wr_data;

  always_comb begin
    owner_valid = grant_q & bus.req_valid;
    beat        = (|owner_valid) & ~bus.wr_full;
    abandon     = (state_q == ST_BUSY) & ~(|owner_valid) & ~bus.wr_full;
    last_hit    = |(grant_q & bus.req_last);
    cnt_inc     = beat_cnt_q + 1'b1;
    burst_end   = (beat & (last_hit | (cnt_inc == CNT_W'(MAX_BURST)))) | abandon;
    next_ptr    = (owner_idx_q == PTR_W'(NREQ - 1)) ? '0 : owner_idx_q + 1'b1;
    // A handoff searches from the slot after the ending owner, not from rr_ptr_q.
    pick_ptr    = (state_q == ST_IDLE) ? rr_ptr_q : next_ptr;
  end

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req      (bus.req_valid),
    .ptr      (pick_ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    owner_idx_d = owner_idx_q;
    beat_cnt_d  = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          state_d     = ST_BUSY;
          grant_d     = pick;
          owner_idx_d = pick_idx;
          beat_cnt_d  = '0;
        end
      end
      default: begin
        if (beat) beat_cnt_d = cnt_inc;
        if (burst_end) begin
          rr_ptr_d   = next_ptr;
          beat_cnt_d = '0;
          if (|bus.req_valid) begin
            grant_d     = pick;
            owner_idx_d = pick_idx;
          end else begin
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      owner_idx_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_idx_q <= owner_idx_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  // AND-OR mux keyed on grant, so the write data is zero whenever nobody owns the port.
  always_comb begin
    wr_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) wr_data = wr_data | bus.req_data[i*DATASIZE +: DATASIZE];
    end
  end

  assign bus.grant        = grant_q;
  assign bus.busy         = (state_q == ST_BUSY);
  assign bus.req_ready    = grant_q & {NREQ{~bus.wr_full}};
  assign bus.fifo_wr_en   = beat;
  assign bus.fifo_wr_data = wr_data;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed cycles push expected beats,
// and negedge monitors pop and compare each fifo_wr_en beat of two instances.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic wr_clk = 1'b0;
  logic wr_rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  logic [NREQ+DW-1:0] exp_q1[$];
  logic [NREQ+DW-1:0] exp_q2[$];

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DATASIZE(DW)) bus ();
  fifo_wr_arbiter_if #(.NREQ(NREQ), .DATASIZE(DW)) bus2 ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DATASIZE(DW), .MAX_BURST(4)) dut (
    .wr_clk (wr_clk),
    .wr_rst (wr_rst),
    .bus    (bus)
  );

  fifo_wr_arbiter #(.NREQ(NREQ), .DATASIZE(DW), .MAX_BURST(1)) dut_mb1 (
    .wr_clk (wr_clk),
    .wr_rst (wr_rst),
    .bus    (bus2)
  );

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each accepted beat must match the oldest pending {grant, data} expectation.
  always @(negedge wr_clk) begin
    if (!wr_rst && bus.fifo_wr_en !== 1'b0) begin
      if (exp_q1.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL dut_unexpected_beat: got grant=%b data=0x%0h, expected no write at %0t",
                 bus.grant, bus.fifo_wr_data, $time);
      end else begin
        checkVal("dut_beat", 32'({bus.grant, bus.fifo_wr_data}), 32'(exp_q1.pop_front()));
      end
    end
  end

  always @(negedge wr_clk) begin
    if (!wr_rst && bus2.fifo_wr_en !== 1'b0) begin
      if (exp_q2.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL mb1_unexpected_beat: got grant=%b data=0x%0h, expected no write at %0t",
                 bus2.grant, bus2.fifo_wr_data, $time);
      end else begin
        checkVal("mb1_beat", 32'({bus2.grant, bus2.fifo_wr_data}), 32'(exp_q2.pop_front()));
      end
    end
  end

  // Drives one cycle of requester/FIFO inputs; exp_idx >= 0 means a beat from that requester is due.
  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic f, input int exp_idx);
    @(posedge wr_clk);
    #1;
    cyc++;
    bus.req_valid = v;
    bus.req_last  = l;
    bus.wr_full   = f;
    for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = {4'(i), 4'(cyc)};
    if (exp_idx >= 0) exp_q1.push_back({4'(1 << exp_idx), 4'(exp_idx), 4'(cyc)});
  endtask

  task automatic checkOutput(input string name, input logic [3:0] g, input logic b);
    @(negedge wr_clk);
    checkVal({name, "_grant"}, 32'(bus.grant), 32'(g));
    checkVal({name, "_busy"}, 32'(bus.busy), 32'(b));
  endtask

  task automatic step(input string name, input logic [3:0] v, input logic [3:0] l, input logic f,
                      input int exp_idx, input logic [3:0] g, input logic b);
    applyStimulus(v, l, f, exp_idx);
    checkOutput(name, g, b);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_valid  = '0;
    bus.req_last   = '0;
    bus.req_data   = '0;
    bus.wr_full    = 1'b0;
    bus2.req_valid = '0;
    bus2.req_last  = '0;
    bus2.wr_full   = 1'b0;
    for (int i = 0; i < NREQ; i++) bus2.req_data[i*DW +: DW] = 8'(8'h50 + i);

    #12;
    checkVal("reset_grant", 32'(bus.grant), 32'd0);
    checkVal("reset_busy", 32'(bus.busy), 32'd0);
    checkVal("reset_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    checkVal("reset_ready", 32'(bus.req_ready), 32'd0);
    checkVal("reset_wr_data", 32'(bus.fifo_wr_data), 32'd0);
    #10;
    wr_rst = 1'b0;

    // Two requesters, no last: four beats each, gapless handoff, then back to requester 0.
    step("t1_idle", 4'b0101, 4'b0000, 1'b0, -1, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) step("t1_r0", 4'b0101, 4'b0000, 1'b0, 0, 4'b0001, 1'b1);
    for (int k = 0; k < 4; k++) step("t1_r2", 4'b0101, 4'b0000, 1'b0, 2, 4'b0100, 1'b1);
    step("t1_back_r0", 4'b0101, 4'b0000, 1'b0, 0, 4'b0001, 1'b1);
    step("t1_abandon", 4'b0000, 4'b0000, 1'b0, -1, 4'b0001, 1'b1);
    step("t1_idle_end", 4'b0000, 4'b0000, 1'b0, -1, 4'b0000, 1'b0);

    // Requester 1 alone ends on last; its valid is still high in that cycle so it is re-granted.
    step("t2_idle", 4'b0010, 4'b0000, 1'b0, -1, 4'b0000, 1'b0);
    step("t2_beat1", 4'b0010, 4'b0000, 1'b0, 1, 4'b0010, 1'b1);
    step("t2_last", 4'b0010, 4'b0010, 1'b0, 1, 4'b0010, 1'b1);
    step("t2_regrant", 4'b0000, 4'b0000, 1'b0, -1, 4'b0010, 1'b1);
    step("t2_idle_end", 4'b0000, 4'b0000, 1'b0, -1, 4'b0000, 1'b0);

    // rr_ptr is 2: requester 3 wins, stalls three cycles on wr_full, still gets exactly 4 beats.
    step("t3_idle", 4'b1001, 4'b0000, 1'b0, -1, 4'b0000, 1'b0);
    step("t3_beat1", 4'b1001, 4'b0000, 1'b0, 3, 4'b1000, 1'b1);
    step("t3_beat2", 4'b1001, 4'b0000, 1'b0, 3, 4'b1000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step("t3_full", 4'b1001, 4'b0000, 1'b1, -1, 4'b1000, 1'b1);
      checkVal("t3_full_ready", 32'(bus.req_ready), 32'd0);
      checkVal("t3_full_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    end
    step("t3_beat3", 4'b1001, 4'b0000, 1'b0, 3, 4'b1000, 1'b1);
    checkVal("t3_ready", 32'(bus.req_ready), 32'b1000);
    step("t3_beat4", 4'b1001, 4'b0000, 1'b0, 3, 4'b1000, 1'b1);
    step("t3_handoff_r0", 4'b1001, 4'b0000, 1'b0, 0, 4'b0001, 1'b1);
    step("t3_abandon", 4'b0000, 4'b0000, 1'b0, -1, 4'b0001, 1'b1);

    // rr_ptr is 1: owner drops valid while full (held), then while not full (released).
    step("t5_idle", 4'b0110, 4'b0000, 1'b0, -1, 4'b0000, 1'b0);
    step("t5_beat", 4'b0110, 4'b0000, 1'b0, 1, 4'b0010, 1'b1);
    step("t5_drop_full", 4'b0100, 4'b0000, 1'b1, -1, 4'b0010, 1'b1);
    step("t5_drop_free", 4'b0100, 4'b0000, 1'b0, -1, 4'b0010, 1'b1);
    step("t5_handoff_r2", 4'b0100, 4'b0000, 1'b0, 2, 4'b0100, 1'b1);
    step("t5_abandon", 4'b0000, 4'b0000, 1'b0, -1, 4'b0100, 1'b1);
    step("t5_idle_end", 4'b0000, 4'b0000, 1'b0, -1, 4'b0000, 1'b0);

    // rr_ptr is 3: reset during requester 1's burst clears everything and rr_ptr restarts at 0.
    step("t6_idle", 4'b0010, 4'b0000, 1'b0, -1, 4'b0000, 1'b0);
    step("t6_beat1", 4'b0010, 4'b0000, 1'b0, 1, 4'b0010, 1'b1);
    step("t6_beat2", 4'b0010, 4'b0000, 1'b0, 1, 4'b0010, 1'b1);
    @(posedge wr_clk);
    #3;
    wr_rst = 1'b1;
    #1;
    checkVal("t6_rst_grant", 32'(bus.grant), 32'd0);
    checkVal("t6_rst_busy", 32'(bus.busy), 32'd0);
    checkVal("t6_rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    bus.req_valid = '0;
    @(posedge wr_clk);
    #3;
    wr_rst = 1'b0;
    step("t6_idle_after", 4'b1100, 4'b0000, 1'b0, -1, 4'b0000, 1'b0);
    step("t6_restart_r2", 4'b1100, 4'b0000, 1'b0, 2, 4'b0100, 1'b1);
    step("t6_abandon", 4'b0000, 4'b0000, 1'b0, -1, 4'b0100, 1'b1);
    step("t6_idle_end", 4'b0000, 4'b0000, 1'b0, -1, 4'b0000, 1'b0);

    // MAX_BURST=1 instance, everyone valid: one beat per owner per cycle in rotating order.
    @(posedge wr_clk);
    #1;
    bus2.req_valid = 4'b1111;
    @(negedge wr_clk);
    checkVal("mb1_idle_grant", 32'(bus2.grant), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge wr_clk);
      #1;
      exp_q2.push_back({4'(1 << (k % 4)), 8'(8'h50 + (k % 4))});
      @(negedge wr_clk);
      checkVal("mb1_grant", 32'(bus2.grant), 32'(1 << (k % 4)));
    end
    @(posedge wr_clk);
    #1;
    bus2.req_valid = '0;
    repeat (3) @(posedge wr_clk);
    @(negedge wr_clk);

    checkVal("dut_queue_drained", 32'(exp_q1.size()), 32'd0);
    checkVal("mb1_queue_drained", 32'(exp_q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
